mx_rcvr_frame_ctrl: RTL and testbench
=====================================

# mx_rcvr_frame_ctrl

Frame-level controller that sits directly behind the Manchester receiver (`mx_rcvr2`). It sequences the receiver's byte stream (`data`/`write`/`cardet`/`error`) into whole frames and filters each frame by destination address. Frames are stored in an internal buffer with commit/rollback, and only complete, error-free frames are exposed to the host through a first-word-fall-through read port. It is the single point where receiver bytes become host-visible, so partial or corrupted frames never reach downstream logic.

## Interface
- `MAC_ADDR`, default 8'h40: this station's address; frames whose first byte matches are accepted.
- `BCAST_ADDR`, default 8'h2A: broadcast address (`*`); frames with this first byte are also accepted.
- `DEPTH`, default 64: buffer depth in bytes; must be a power of two, ≥ 4.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `cardet` in 1: carrier detect from the receiver.
- `rx_data` in 8: received byte; valid when `rx_write` = 1.
- `rx_write` in 1: one-cycle strobe, one received byte.
- `rx_error` in 1: receiver error flag.
- `rrd` in 1: host read strobe; pops one byte.
- `rdata` out 8: byte at the head of the committed data; 8'h00 when `rrdy` = 0.
- `rrdy` out 1: committed data available.
- `frame_ok` out 1: one-cycle pulse when a frame is committed.
- `frame_drop` out 1: one-cycle pulse when an accepted frame is discarded.
- `drop_cnt` out 8: count of dropped frames; saturates at 8'hFF.

## Operation
Buffer:
- Circular byte array, `DEPTH` entries.
- Three pointers, each `$clog2(DEPTH)+1` bits wide, wrapping modulo 2·`DEPTH`:
  - `wr_ptr`: tentative write position.
  - `cm_ptr`: end of committed data.
  - `rd_ptr`: host read position.
- Full: `wr_ptr - rd_ptr == DEPTH`.
- `rrdy = (rd_ptr != cm_ptr)`.
- `rdata = buf[rd_ptr]` when `rrdy` = 1, else 8'h00.
- `rrd` with `rrdy` = 1 increments `rd_ptr`; `rrd` with `rrdy` = 0 is ignored.

FSM states: IDLE, BODY, DRAIN.

IDLE:
- `rx_write` with `rx_data` equal to `MAC_ADDR` or `BCAST_ADDR`: store the byte and go to BODY.
- `rx_write` with any other `rx_data`: go to DRAIN. No pulse and no count.
- `rx_error` in IDLE is ignored.

BODY, priority order, evaluated each cycle:
1. `rx_error` = 1: roll back (`wr_ptr <= cm_ptr`), pulse `frame_drop`, increment `drop_cnt`, go to DRAIN.
2. `rx_write` while full: roll back, pulse drop, increment count, go to DRAIN.
3. `cardet` = 0:
   - If the frame length (`wr_ptr - cm_ptr`) is < 2 (runt frame): roll back, pulse drop, increment count, go to IDLE.
   - Otherwise: `cm_ptr <= wr_ptr`, pulse `frame_ok`, go to IDLE.
4. `rx_write` = 1: store the byte, `wr_ptr + 1`.

DRAIN:
- Ignore all bytes.
- Go to IDLE when `cardet` = 0.

Simultaneous events:
- `rx_error` and `cardet` falling in the same cycle: treated as an error (drop).
- `rx_write` and `cardet` = 0 in the same BODY cycle: the byte is discarded and the frame commits without it.
- Host reads are independent of the FSM and may coincide with commit or rollback. Rollback never moves `rd_ptr`.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State IDLE; all pointers 0; `drop_cnt` 0.
  - `frame_ok`, `frame_drop` and `rrdy` are 0; `rdata` is 8'h00.
  - Reset mid-frame discards all buffered data, committed or not.
- Byte store: on the clock edge that samples `rx_write`.
- Commit latency:
  - `frame_ok` is high in the cycle after the edge that samples `cardet` = 0 in BODY.
  - `rrdy` rises in the same cycle as `frame_ok`; `rdata` is valid in that cycle.
- Drop latency: `frame_drop` is high the cycle after the edge that samples the error, overflow or runt condition.
- Read: `rdata` updates to the next byte the cycle after `rrd` is sampled; back-to-back `rrd` is allowed.
- All outputs are registered except `rdata` and `rrdy`, which are combinational from registers.

## Test plan
- Reset: drive `rst` = 0 mid-frame, then release → `rrdy` = 0, `rdata` = 00, `drop_cnt` = 0. A following frame 40 11 is accepted normally.
- Addressed frame: bytes 40 BB FF 00 AA, then `cardet` low → one `frame_ok` pulse, `rrdy` = 1. Five `rrd` strobes return 40, BB, FF, 00, AA, then `rrdy` = 0.
- Filtering: frame 2A 11 → accepted and read back as 2A, 11. Frame 41 22 33 → no pulse, `rrdy` stays 0, `drop_cnt` unchanged. Frame 40 alone → `frame_drop`, `drop_cnt` = 1.
- Error mid-frame: commit frame 40 01, then send 40 BB with `rx_error` asserted → `frame_drop` pulse, `drop_cnt` +1, `wr_ptr` restored. Reading still yields only 40, 01. Error and `cardet` falling together also drops the frame.
- Overflow and wrap, `DEPTH` = 8:
  - A 9-byte frame → drop and `rrdy` = 0.
  - Then a 5-byte frame, read fully, then a 6-byte frame spanning pointer wrap-around → all bytes read back in order.
- Read under commit: hold `rrd` high continuously while a second frame commits → no byte is lost or duplicated, and `rrd` with `rrdy` = 0 has no effect.

Source files
------------

// File: rtl/mx_rcvr_frame_ctrl.sv
// Frame controller behind the Manchester receiver: address filter,
// commit/rollback byte buffer and first-word-fall-through host read port.
module mx_rcvr_frame_ctrl #(
    parameter logic [7:0] MAC_ADDR   = 8'h40,
    parameter logic [7:0] BCAST_ADDR = 8'h2A,
    parameter int         DEPTH      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cardet,
    input  logic [7:0] rx_data,
    input  logic       rx_write,
    input  logic       rx_error,
    input  logic       rrd,
    output logic [7:0] rdata,
    output logic       rrdy,
    output logic       frame_ok,
    output logic       frame_drop,
    output logic [7:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] RUNT_LVL = (AW+1)'(2);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] cm_q, cm_d;
    logic [AW:0] rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ok_q, ok_d;
    logic        drop_q, drop_d;
    logic        we;
    logic        full;
    logic        addr_hit;
    logic [AW:0] used;
    logic [AW:0] len;
    logic [7:0]  mem_q [DEPTH];

    assign used     = wr_q - rd_q;
    assign len      = wr_q - cm_q;
    assign full     = (used == FULL_LVL);
    assign addr_hit = (rx_data == MAC_ADDR) || (rx_data == BCAST_ADDR);

    assign rrdy       = (rd_q != cm_q);
    assign rdata      = rrdy ? mem_q[rd_q[AW-1:0]] : 8'h00;
    assign frame_ok   = ok_q;
    assign frame_drop = drop_q;
    assign drop_cnt   = cnt_q;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cm_d    = cm_q;
        ok_d    = 1'b0;
        drop_d  = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // a full buffer cannot take even the address byte
                if (rx_write && addr_hit && full) begin
                    drop_d  = 1'b1;
                    state_d = DRAIN;
                end else if (rx_write && addr_hit) begin
                    we      = 1'b1;
                    wr_d    = wr_q + ONE;
                    state_d = BODY;
                end else if (rx_write) begin
                    state_d = DRAIN;
                end
            end
            BODY: begin
                if (rx_error || (rx_write && full)) begin
                    wr_d    = cm_q;
                    drop_d  = 1'b1;
                    state_d = DRAIN;
                end else if (!cardet) begin
                    if (len < RUNT_LVL) begin
                        wr_d   = cm_q;
                        drop_d = 1'b1;
                    end else begin
                        cm_d = wr_q;
                        ok_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (rx_write) begin
                    we   = 1'b1;
                    wr_d = wr_q + ONE;
                end
            end
            DRAIN: begin
                if (!cardet) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d = rd_q;
        if (rrd && rrdy) rd_d = rd_q + ONE;
        cnt_d = cnt_q;
        if (drop_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            cm_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cm_q    <= cm_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_q[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_mx_rcvr_frame_ctrl.sv
// Randomised and directed bench for mx_rcvr_frame_ctrl against a
// queue-based frame model.
module tb_mx_rcvr_frame_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cardet = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_write = 1'b0;
    logic       rx_error = 1'b0;
    logic       rrd = 1'b0;
    logic [7:0] rdata;
    logic       rrdy;
    logic       frame_ok;
    logic       frame_drop;
    logic [7:0] drop_cnt;

    mx_rcvr_frame_ctrl #(
        .MAC_ADDR  (8'h40),
        .BCAST_ADDR(8'h2A),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cardet    (cardet),
        .rx_data   (rx_data),
        .rx_write  (rx_write),
        .rx_error  (rx_error),
        .rrd       (rrd),
        .rdata     (rdata),
        .rrdy      (rrdy),
        .frame_ok  (frame_ok),
        .frame_drop(frame_drop),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_ok = 0;
    int n_drop = 0;
    int n_pop = 0;
    bit rand_rd = 0;

    // model: committed bytes, bytes of the frame in flight, frame phase
    logic [7:0] mq[$];
    logic [7:0] cur[$];
    int         mode = 0;
    logic       e_ok = 0;
    logic       e_drop = 0;
    logic [7:0] e_cnt = 0;

    logic [7:0] fb[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_drop();
        e_drop = 1'b1;
        if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
        cur.delete();
    endtask

    always @(posedge clk or negedge rst) begin : mdl
        int  occ;
        bool_hit_blk: begin end
        if (!rst) begin
            mq.delete();
            cur.delete();
            mode   = 0;
            e_ok   = 0;
            e_drop = 0;
            e_cnt  = 0;
        end else begin
            occ    = mq.size() + cur.size();
            e_ok   = 0;
            e_drop = 0;
            if (rrd && mq.size() > 0) void'(mq.pop_front());
            case (mode)
                0: if (rx_write) begin
                    if (rx_data == 8'h40 || rx_data == 8'h2A) begin
                        if (occ == DEPTH) begin
                            model_drop();
                            mode = 2;
                        end else begin
                            cur.push_back(rx_data);
                            mode = 1;
                        end
                    end else begin
                        mode = 2;
                    end
                end
                1: begin
                    if (rx_error || (rx_write && occ == DEPTH)) begin
                        model_drop();
                        mode = 2;
                    end else if (!cardet) begin
                        if (cur.size() < 2) begin
                            model_drop();
                        end else begin
                            foreach (cur[i]) mq.push_back(cur[i]);
                            cur.delete();
                            e_ok = 1'b1;
                        end
                        mode = 0;
                    end else if (rx_write) begin
                        cur.push_back(rx_data);
                    end
                end
                default: if (!cardet) mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("rrdy", rrdy, mq.size() != 0);
        chk("rdata", rdata, (mq.size() != 0) ? mq[0] : 8'h00);
        chk("frame_ok", frame_ok, e_ok);
        chk("frame_drop", frame_drop, e_drop);
        chk("drop_cnt", drop_cnt, e_cnt);
        if (frame_ok) n_ok++;
        if (frame_drop) n_drop++;
        if (rrd && rrdy) n_pop++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rd) rrd = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int n, input int err_at, input bit err_fall, input bit wr_fall);
        cardet = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            rx_data  = fb[i];
            rx_write = 1'b1;
            if (wr_fall && i == n - 1) cardet = 1'b0;
            tick();
            rx_write = 1'b0;
            if (i == err_at) begin
                rx_error = 1'b1;
                tick();
                rx_error = 1'b0;
            end
            if (cardet) tick();
        end
        if (cardet) begin
            if (err_fall) rx_error = 1'b1;
            cardet = 1'b0;
            tick();
            rx_error = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic rd_exp(input logic [7:0] v);
        int t;
        t = 0;
        while (!rrdy && t < 20) begin
            tick();
            t++;
        end
        chk("rd_byte", rdata, v);
        rrd = 1'b1;
        tick();
        rrd = 1'b0;
    endtask

    task automatic set2(input logic [7:0] a, input logic [7:0] b);
        fb[0] = a;
        fb[1] = b;
    endtask

    initial begin
        int ok0;
        int pop0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // reset mid-frame discards committed and pending data
        fb[0] = 8'h40;
        send(1, -1, 0, 0);
        chk("runt_cnt", drop_cnt, 8'd1);
        set2(8'h40, 8'h11);
        send(2, -1, 0, 0);
        cardet   = 1'b1;
        rx_data  = 8'h40;
        rx_write = 1'b1;
        tick();
        rx_write = 1'b0;
        tick();
        rst = 1'b0;
        #2;
        chk("rst_rrdy", rrdy, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_cnt", drop_cnt, 8'd0);
        tick();
        rst    = 1'b1;
        cardet = 1'b0;
        tick();
        send(2, -1, 0, 0);
        rd_exp(8'h40);
        rd_exp(8'h11);
        chk("rst_empty", rrdy, 1'b0);

        // addressed frame
        ok0 = n_ok;
        fb[0] = 8'h40; fb[1] = 8'hBB; fb[2] = 8'hFF; fb[3] = 8'h00; fb[4] = 8'hAA;
        send(5, -1, 0, 0);
        chk("ok_pulses", n_ok - ok0, 1);
        rd_exp(8'h40); rd_exp(8'hBB); rd_exp(8'hFF); rd_exp(8'h00); rd_exp(8'hAA);
        chk("addr_empty", rrdy, 1'b0);

        // filtering
        set2(8'h2A, 8'h11);
        send(2, -1, 0, 0);
        rd_exp(8'h2A);
        rd_exp(8'h11);
        fb[0] = 8'h41; fb[1] = 8'h22; fb[2] = 8'h33;
        send(3, -1, 0, 0);
        chk("filt_rrdy", rrdy, 1'b0);
        chk("filt_cnt", drop_cnt, 8'd0);
        fb[0] = 8'h40;
        send(1, -1, 0, 0);
        chk("runt_cnt2", drop_cnt, 8'd1);

        // error mid-frame, and error with carrier loss
        set2(8'h40, 8'h01);
        send(2, -1, 0, 0);
        set2(8'h40, 8'hBB);
        send(2, 1, 0, 0);
        chk("err_cnt", drop_cnt, 8'd2);
        rd_exp(8'h40);
        rd_exp(8'h01);
        chk("err_empty", rrdy, 1'b0);
        send(2, -1, 1, 0);
        chk("errfall_cnt", drop_cnt, 8'd3);
        chk("errfall_rrdy", rrdy, 1'b0);

        // overflow, then a frame spanning pointer wrap
        fb[0] = 8'h40;
        for (int i = 1; i < 9; i++) fb[i] = 8'(i);
        send(9, -1, 0, 0);
        chk("ovf_cnt", drop_cnt, 8'd4);
        chk("ovf_rrdy", rrdy, 1'b0);
        for (int i = 1; i < 5; i++) fb[i] = 8'(8'h50 + i);
        send(5, -1, 0, 0);
        for (int i = 0; i < 5; i++) rd_exp(fb[i]);
        fb[0] = 8'h2A;
        for (int i = 1; i < 6; i++) fb[i] = 8'(8'hC0 + i);
        send(6, -1, 0, 0);
        for (int i = 0; i < 6; i++) rd_exp(fb[i]);
        chk("wrap_empty", rrdy, 1'b0);

        // write colliding with carrier loss: last byte is discarded
        fb[0] = 8'h40; fb[1] = 8'h77; fb[2] = 8'h99;
        send(3, -1, 0, 1);
        rd_exp(8'h40);
        rd_exp(8'h77);
        chk("coll_empty", rrdy, 1'b0);

        // continuous read while a second frame commits
        fb[0] = 8'h40; fb[1] = 8'hA1; fb[2] = 8'hA2;
        send(3, -1, 0, 0);
        pop0 = n_pop;
        rrd = 1'b1;
        fb[0] = 8'h2A; fb[1] = 8'hB1; fb[2] = 8'hB2; fb[3] = 8'hB3;
        send(4, -1, 0, 0);
        repeat (10) tick();
        rrd = 1'b0;
        tick();
        chk("hold_pops", n_pop - pop0, 7);
        chk("hold_empty", rrdy, 1'b0);

        // random traffic with random host reads
        rand_rd = 1;
        for (int f = 0; f < 60; f++) begin
            int n;
            int sel;
            n   = $urandom_range(1, 7);
            sel = $urandom_range(0, 3);
            fb[0] = (sel == 0) ? 8'h2A : (sel == 3) ? 8'($urandom) : 8'h40;
            for (int i = 1; i < n; i++) fb[i] = 8'($urandom);
            send(n, ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
        end
        rand_rd = 0;
        rrd = 1'b1;
        repeat (20) tick();
        rrd = 1'b0;
        tick();
        chk("final_empty", rrdy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
